// File: rtl/line_burst_adapter.sv
// Converts single-cycle 256-bit cache line fills/writebacks into 4-beat 64-bit memory bursts.
// Optional posted writebacks: define LINE_BURST_POSTED_WRITE_EN to acknowledge a writeback on its first beat cycle.
module line_burst_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_read,
  input  logic         line_write,
  input  logic [31:0]  line_address,
  input  logic [255:0] line_wdata,
  output logic [255:0] line_rdata,
  output logic         line_resp,
  output logic [31:0]  burst_address,
  output logic         burst_read,
  output logic         burst_write,
  output logic [63:0]  burst_wdata,
  input  logic [63:0]  burst_rdata,
  input  logic         burst_resp
);

  typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   rdata_q, rdata_d;
`ifdef LINE_BURST_POSTED_WRITE_EN
  logic           posted_q, posted_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LINE_BURST_POSTED_WRITE_EN
    posted_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A simultaneous read and write request is served as the write.
        if (line_write) begin
          addr_d  = {line_address[31:5], 5'b0};
          wdata_d = line_wdata;
          cnt_d   = 2'd0;
          state_d = WR_BEAT;
`ifdef LINE_BURST_POSTED_WRITE_EN
          posted_d = 1'b1;
`endif
        end else if (line_read) begin
          addr_d  = {line_address[31:5], 5'b0};
          cnt_d   = 2'd0;
          state_d = RD_BEAT;
        end
      end
      RD_BEAT: begin
        if (burst_resp) begin
          rdata_d[{cnt_q, 6'b0} +: 64] = burst_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      WR_BEAT: begin
        if (burst_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef LINE_BURST_POSTED_WRITE_EN
            state_d = IDLE;
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 256'd0;
      rdata_q <= 256'd0;
`ifdef LINE_BURST_POSTED_WRITE_EN
      posted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef LINE_BURST_POSTED_WRITE_EN
      posted_q <= posted_d;
`endif
    end
  end

  // Strobes decode straight from the state register so reset drops them immediately.
  assign burst_read    = (state_q == RD_BEAT);
  assign burst_write   = (state_q == WR_BEAT);
  assign burst_address = addr_q;
  assign burst_wdata   = wdata_q[{cnt_q, 6'b0} +: 64];
  assign line_rdata    = rdata_q;
`ifdef LINE_BURST_POSTED_WRITE_EN
  assign line_resp     = (state_q == DONE) | posted_q;
`else
  assign line_resp     = (state_q == DONE);
`endif

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: vector table of line transactions plus reset/stray/posted sequences.
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read, burst_write;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  line_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_address(burst_address), .burst_read(burst_read),
    .burst_write(burst_write), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  typedef struct {
    logic         wr;
    logic         both;
    logic [31:0]  addr;
    logic [255:0] data;      // write line, or read beats {b3,b2,b1,b0}
    int           gap;
    logic [31:0]  exp_addr;
    logic [255:0] exp_rdata; // line_rdata expected after the transaction
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [255:0] beats, input int gap,
                         input logic [31:0] exp_addr, input logic [255:0] exp_rd);
    line_read = 1'b1; line_address = addr;
    tick();
    line_read = 1'b0; line_address = ~addr;
    check("rd_burst_read", burst_read, 1'b1);
    check("rd_burst_write", burst_write, 1'b0);
    check("rd_addr", burst_address, exp_addr);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        check("rd_gap_resp", line_resp, 1'b0);
        check("rd_gap_read", burst_read, 1'b1);
      end
      burst_rdata = beats[b*64 +: 64];
      burst_resp = 1'b1;
      tick();
      burst_resp = 1'b0;
      burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    check("rd_done_resp", line_resp, 1'b1);
    check("rd_done_read", burst_read, 1'b0);
    check("rd_rdata", line_rdata, exp_rd);
    tick();
    check("rd_idle_resp", line_resp, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] wd, input int gap, input logic both,
                          input logic [31:0] exp_addr, input logic [255:0] exp_rd);
    line_write = 1'b1; line_read = both; line_address = addr; line_wdata = wd;
    tick();
    line_write = 1'b0; line_read = 1'b0; line_address = ~addr; line_wdata = ~wd;
    check("wr_burst_write", burst_write, 1'b1);
    check("wr_burst_read", burst_read, 1'b0);
    check("wr_addr", burst_address, exp_addr);
`ifdef LINE_BURST_POSTED_WRITE_EN
    check("wr_posted_resp", line_resp, 1'b1);
`else
    check("wr_early_resp", line_resp, 1'b0);
`endif
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        check("wr_gap_wdata", burst_wdata, wd[b*64 +: 64]);
        tick();
        check("wr_gap_resp", line_resp, 1'b0);
        check("wr_gap_write", burst_write, 1'b1);
      end
      check("wr_wdata", burst_wdata, wd[b*64 +: 64]);
      burst_resp = 1'b1;
      tick();
      burst_resp = 1'b0;
    end
    check("wr_end_write", burst_write, 1'b0);
`ifdef LINE_BURST_POSTED_WRITE_EN
    check("wr_end_no_resp", line_resp, 1'b0);
`else
    check("wr_done_resp", line_resp, 1'b1);
    tick();
    check("wr_idle_resp", line_resp, 1'b0);
`endif
    check("wr_rdata_kept", line_rdata, exp_rd);
  endtask

  initial begin
    logic [255:0] exp_rd;
    logic [255:0] last_wd;
    logic [255:0] rb0;
    logic [255:0] rb2;
    logic [255:0] w1;
    logic [255:0] w3;
    rb0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rb2 = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};
    w1  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0};
    w3  = {64'h4444_0000_0000_DDDD, 64'h3333_0000_0000_CCCC, 64'h2222_0000_0000_BBBB, 64'h1111_0000_0000_AAAA};
    vecs[0] = '{wr:1'b0, both:1'b0, addr:32'h0000_1234, data:rb0, gap:0, exp_addr:32'h0000_1220, exp_rdata:rb0};
    vecs[1] = '{wr:1'b1, both:1'b0, addr:32'hABCD_EF1F, data:w1,  gap:2, exp_addr:32'hABCD_EF00, exp_rdata:rb0};
    vecs[2] = '{wr:1'b0, both:1'b0, addr:32'hFFFF_FFFF, data:rb2, gap:1, exp_addr:32'hFFFF_FFE0, exp_rdata:rb2};
    vecs[3] = '{wr:1'b1, both:1'b1, addr:32'h0000_0047, data:w3,  gap:0, exp_addr:32'h0000_0040, exp_rdata:rb2};

    rst = 1'b0;
    line_read = 1'b0; line_write = 1'b0; line_address = 32'hFFFF_FFFF; line_wdata = '1;
    burst_rdata = 64'd0; burst_resp = 1'b0;
    tick(); tick();
    check("rst_burst_read", burst_read, 1'b0);
    check("rst_burst_write", burst_write, 1'b0);
    check("rst_line_resp", line_resp, 1'b0);
    check("rst_addr", burst_address, 32'd0);
    check("rst_rdata", line_rdata, 256'd0);
    check("rst_wdata", burst_wdata, 64'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].both, vecs[i].exp_addr, vecs[i].exp_rdata);
      else
        do_read(vecs[i].addr, vecs[i].data, vecs[i].gap, vecs[i].exp_addr, vecs[i].exp_rdata);
    end
    last_wd = w3;

    // Stray acknowledges in IDLE must not move state or the beat counter.
    burst_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray_read", burst_read, 1'b0);
      check("stray_write", burst_write, 1'b0);
      check("stray_resp", line_resp, 1'b0);
      check("stray_cnt", burst_wdata, last_wd[63:0]);
    end
    burst_resp = 1'b0;
    do_read(32'h0000_0080, rb0, 0, 32'h0000_0080, rb0);

    // Reset after two read beats abandons the burst.
    line_read = 1'b1; line_address = 32'h0000_3000;
    tick();
    line_read = 1'b0;
    burst_rdata = 64'h5555_5555_5555_5555; burst_resp = 1'b1;
    tick(); tick();
    burst_resp = 1'b0;
    check("mid_burst_read", burst_read, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_burst_read", burst_read, 1'b0);
    check("arst_resp", line_resp, 1'b0);
    check("arst_rdata", line_rdata, 256'd0);
    check("arst_addr", burst_address, 32'd0);
    tick();
    check("arst_hold_resp", line_resp, 1'b0);
    rst = 1'b1;
    tick();
    check("post_rst_resp", line_resp, 1'b0);
    check("post_rst_read", burst_read, 1'b0);
    exp_rd = rb2;
    do_read(32'h0000_3010, rb2, 0, 32'h0000_3000, exp_rd);

`ifdef LINE_BURST_POSTED_WRITE_EN
    // A read arriving during a posted writeback waits for the burst to drain.
    line_write = 1'b1; line_address = 32'h0000_0100; line_wdata = w1;
    tick();
    line_write = 1'b0; line_read = 1'b1; line_address = 32'h0000_2000;
    check("pw_resp", line_resp, 1'b1);
    for (int b = 0; b < 4; b++) begin
      check("pw_write", burst_write, 1'b1);
      check("pw_no_read", burst_read, 1'b0);
      check("pw_wdata", burst_wdata, w1[b*64 +: 64]);
      burst_resp = 1'b1;
      tick();
      burst_resp = 1'b0;
      check("pw_no_resp", line_resp, 1'b0);
    end
    check("pw_end_write", burst_write, 1'b0);
    check("pw_end_read", burst_read, 1'b0);
    tick();
    line_read = 1'b0;
    check("pw_read_start", burst_read, 1'b1);
    check("pw_read_addr", burst_address, 32'h0000_2000);
    for (int b = 0; b < 4; b++) begin
      burst_rdata = rb0[b*64 +: 64];
      burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    check("pw_read_resp", line_resp, 1'b1);
    check("pw_read_rdata", line_rdata, rb0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
